// File: rtl/lead_one_scanner.sv
// Multi-cycle leading-one detector feeding the normaliser's exponent stage.
// The mantissa is latched on acceptance and scanned MSB-first, one CHUNK-wide
// slice per cycle. The result is held on a valid/ready output until consumed.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   in_mant            unnormalised mantissa sum, WIDTH bits
//   in_exp_max         max operand exponent, passed through to exp_max
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   leading_pos        index of the most significant set bit of in_mant
//   exp_max            copy of in_exp_max captured on acceptance
//   zero               in_mant was all zeros (leading_pos forced to 0)
module lead_one_scanner #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned CHUNK = 10,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned POS_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp_max,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] leading_pos,
  output logic [EXP_W-1:0] exp_max,
  output logic             zero
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned ENC_W      = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mant_q, mant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [POS_W-1:0]   pos_d;
  logic [EXP_W-1:0]   exp_d;
  logic               zero_d;

  logic [POS_W-1:0]   base;
  logic [CHUNK-1:0]   chunk;
  logic [ENC_W-1:0]   enc;

  // Highest set bit within one chunk; 0 when the chunk is empty.
  function automatic logic [ENC_W-1:0] hi_bit(input logic [CHUNK-1:0] v);
    logic [ENC_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < CHUNK; b++) begin
      if (v[b]) r = ENC_W'(b);
    end
    return r;
  endfunction

  // Slice under inspection this cycle and its priority encoding.
  always_comb begin
    base  = POS_W'(idx_q) * POS_W'(CHUNK);
    chunk = CHUNK'(mant_q >> base);
    enc   = hi_bit(chunk);
  end

  // Next-state and next-data logic.
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    idx_d   = idx_q;
    pos_d   = leading_pos;
    exp_d   = exp_max;
    zero_d  = zero;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d  = in_mant;
          exp_d   = in_exp_max;
          idx_d   = IDX_W'(NUM_CHUNKS - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk != '0) begin
          pos_d   = base + POS_W'(enc);
          zero_d  = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          pos_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = IDX_W'(idx_q - 1'b1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      idx_q       <= '0;
      leading_pos <= '0;
      exp_max     <= '0;
      zero        <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      idx_q       <= idx_d;
      leading_pos <= pos_d;
      exp_max     <= exp_d;
      zero        <= zero_d;
      in_ready    <= (state_d == IDLE);
      out_valid   <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_lead_one_scanner.sv
// Randomised self-checking bench for lead_one_scanner against a simple
// whole-word leading-one reference model.
module tb_lead_one_scanner;

  localparam int unsigned WIDTH = 50;
  localparam int unsigned CHUNK = 10;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned POS_W = 6;
  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp_max;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] leading_pos;
  logic [EXP_W-1:0] exp_max;
  logic             zero;

  int checks = 0;
  int errors = 0;

  lead_one_scanner #(
    .WIDTH(WIDTH), .CHUNK(CHUNK), .EXP_W(EXP_W), .POS_W(POS_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp_max(in_exp_max),
    .out_valid(out_valid), .out_ready(out_ready),
    .leading_pos(leading_pos), .exp_max(exp_max), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: scan the whole word for the top set bit, then derive how many
  // chunks the MSB-first scan must visit.
  task automatic model(input logic [WIDTH-1:0] m, output int pos, output bit z, output int k);
    pos = 0;
    z   = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) begin
        pos = i;
        z   = 1'b0;
        break;
      end
    end
    k = z ? int'(NUM_CHUNKS) : int'(NUM_CHUNKS) - pos / int'(CHUNK);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand and return #1 after the edge that accepts it.
  task automatic start_op(input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e);
    int guard = 0;
    in_valid   = 1'b1;
    in_mant    = m;
    in_exp_max = e;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid   = 1'b0;
    in_mant    = WIDTH'({$urandom, $urandom});
    in_exp_max = EXP_W'($urandom);
    check("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Wait for the result and check latency and payload.
  task automatic wait_result(input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e);
    int pos, k, lat;
    bit z;
    model(m, pos, z, k);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(k));
    check("leading_pos", 64'(leading_pos), 64'(pos));
    check("exp_max", 64'(exp_max), 64'(e));
    check("zero", 64'(zero), 64'(z));
    check("done_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Hold backpressure for some cycles, then consume and expect IDLE.
  task automatic release_op(input int stall);
    logic [POS_W-1:0] p;
    logic [EXP_W-1:0] e;
    logic             z;
    p = leading_pos;
    e = exp_max;
    z = zero;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_hold", 64'({p, e, z}), 64'({leading_pos, exp_max, zero}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e, input int stall);
    start_op(m, e);
    wait_result(m, e);
    release_op(stall);
  endtask

  initial begin
    logic [WIDTH-1:0] m, m2;
    logic [EXP_W-1:0] e, e2;
    int               seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = '0; in_exp_max = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_pos", 64'(leading_pos), 64'd0);
    check("rst_exp", 64'(exp_max), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);

    // Directed boundary cases.
    m = '0; m[49] = 1'b1;
    run_op(m, 8'h80, 0);
    run_op(WIDTH'(1), 8'h11, 0);
    run_op('0, 8'h22, 1);
    m = '0; m[23] = 1'b1; m[7] = 1'b1;
    run_op(m, 8'h33, 0);
    m = '0; m[40] = 1'b1;
    run_op(m, 8'h44, 6);

    // Back-to-back: next operand waits through the DONE exit cycle.
    m = '0; m[12] = 1'b1;
    m2 = '0; m2[45] = 1'b1; m2[3] = 1'b1;
    e = 8'h5a; e2 = 8'ha5;
    start_op(m, e);
    wait_result(m, e);
    in_valid = 1'b1; in_mant = m2; in_exp_max = e2; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b_exit_valid", 64'(out_valid), 64'd0);
    check("b2b_exit_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_accepted", 64'(in_ready), 64'd0);
    wait_result(m2, e2);
    release_op(0);

    // Reset during the second scan cycle of a zero mantissa.
    start_op('0, 8'h77);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_pos", 64'(leading_pos), 64'd0);
    check("mid_rst_exp", 64'(exp_max), 64'd0);
    check("mid_rst_zero", 64'(zero), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_rst_stale", 64'(seen), 64'd0);
    m = '0; m[30] = 1'b1;
    run_op(m, 8'h3c, 0);

    // Randomised operands with varied leading-one positions and stalls.
    for (int n = 0; n < 60; n++) begin
      m = WIDTH'({$urandom, $urandom} >> $urandom_range(14, 64));
      e = EXP_W'($urandom);
      run_op(m, e, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
